// File: rtl/fp_accumulator.sv
// fp_accumulator: running FP32 sum fed by the FP multiplier product stream.
// Sequential IDLE -> ALIGN -> ADD -> NORM datapath, one normalize shift per
// cycle. Exponent 0 is treated as zero, results truncate, no Inf/NaN.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_valid/ready  operand handshake, in_data = {sign, exp, man}
//   clear           synchronous clear of sum and sticky flags (IDLE only)
//   acc_out         registered running sum
//   out_valid       one-cycle pulse when acc_out was just written
//   busy            FSM not in IDLE
//   ovf, uf         sticky exponent overflow / underflow flush
module fp_accumulator #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_data,
  input  logic                   clear,
  output logic [EXP_W+MAN_W:0]   acc_out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   ovf,
  output logic                   uf
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int M = MAN_W + 1;
  typedef logic [EXP_W:0] xexp_t;  // one spare bit to see the carry-out exponent
  localparam xexp_t            EXP_MAX = xexp_t'(2 * BIAS);
  localparam xexp_t            EXP_ONE = xexp_t'(1);
  localparam logic [EXP_W-1:0] SH_LIM  = EXP_W'(M);

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic          sign_q, sign_d, sub_q, sub_d;
  xexp_t         exp_q, exp_d;
  logic [M-1:0]  ma_q, ma_d, mb_q, mb_d;
  logic          out_valid_q, out_valid_d, ovf_q, ovf_d, uf_q, uf_d;

  // ALIGN / ADD combinational helpers
  logic             a_zero, b_zero, swap;
  logic [W-1:0]     op_hi, op_lo;
  logic [EXP_W-1:0] d_sh;
  logic [M-1:0]     m_lo_sh;
  logic [M:0]       sum;
  logic [M-1:0]     diff, m_add;
  xexp_t            e_add;

  assign a_zero  = (a_q[W-2 -: EXP_W] == '0);
  assign b_zero  = (b_q[W-2 -: EXP_W] == '0);
  // {exp, man} compares as a magnitude, so this orders by exp then mantissa
  assign swap    = (b_q[W-2:0] > a_q[W-2:0]);
  assign op_hi   = swap ? b_q : a_q;
  assign op_lo   = swap ? a_q : b_q;
  assign d_sh    = op_hi[W-2 -: EXP_W] - op_lo[W-2 -: EXP_W];
  assign m_lo_sh = (d_sh >= SH_LIM) ? '0 : ({1'b1, op_lo[MAN_W-1:0]} >> d_sh);
  assign sum     = {1'b0, ma_q} + {1'b0, mb_q};
  assign diff    = ma_q - mb_q;  // |A| >= |B| so this never wraps
  assign m_add   = sum[M] ? sum[M:1] : sum[M-1:0];
  assign e_add   = exp_q + xexp_t'(sum[M]);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!clear && in_valid) state_d = ALIGN;
      ALIGN: state_d = (a_zero || b_zero) ? IDLE : ADD;
      ADD: begin
        if (!sub_q && e_add > EXP_MAX)  state_d = IDLE;
        else if (sub_q && diff == '0)   state_d = IDLE;
        else                            state_d = NORM;
      end
      NORM:  if (ma_q[M-1] || exp_q <= EXP_ONE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath and result registers
  always_comb begin
    a_d = a_q; b_d = b_q; acc_d = acc_q;
    sign_d = sign_q; sub_d = sub_q; exp_d = exp_q;
    ma_d = ma_q; mb_d = mb_q;
    out_valid_d = 1'b0; ovf_d = ovf_q; uf_d = uf_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          acc_d = '0; ovf_d = 1'b0; uf_d = 1'b0;
        end else if (in_valid) begin
          a_d = acc_q; b_d = in_data;
        end
      end
      ALIGN: begin
        if (a_zero || b_zero) begin
          acc_d = a_zero ? (b_zero ? '0 : b_q) : a_q;
          out_valid_d = 1'b1;
        end else begin
          sign_d = op_hi[W-1];
          sub_d  = a_q[W-1] ^ b_q[W-1];
          exp_d  = {1'b0, op_hi[W-2 -: EXP_W]};
          ma_d   = {1'b1, op_hi[MAN_W-1:0]};
          mb_d   = m_lo_sh;
        end
      end
      ADD: begin
        if (!sub_q) begin
          if (e_add > EXP_MAX) begin
            // saturate to the largest finite magnitude
            acc_d = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            ovf_d = 1'b1; out_valid_d = 1'b1;
          end else begin
            ma_d = m_add; exp_d = e_add;
          end
        end else if (diff == '0) begin
          acc_d = '0; out_valid_d = 1'b1;
        end else begin
          ma_d = diff;
        end
      end
      NORM: begin
        if (ma_q[M-1]) begin
          acc_d = {sign_q, exp_q[EXP_W-1:0], ma_q[MAN_W-1:0]};
          out_valid_d = 1'b1;
        end else if (exp_q > EXP_ONE) begin
          ma_d = ma_q << 1; exp_d = exp_q - EXP_ONE;
        end else begin
          // another shift would need exponent 0: flush
          acc_d = '0; uf_d = 1'b1; out_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; acc_q <= '0;
      sign_q <= 1'b0; sub_q <= 1'b0; exp_q <= '0;
      ma_q <= '0; mb_q <= '0;
      out_valid_q <= 1'b0; ovf_q <= 1'b0; uf_q <= 1'b0;
    end else begin
      a_q <= a_d; b_q <= b_d; acc_q <= acc_d;
      sign_q <= sign_d; sub_q <= sub_d; exp_q <= exp_d;
      ma_q <= ma_d; mb_q <= mb_d;
      out_valid_q <= out_valid_d; ovf_q <= ovf_d; uf_q <= uf_d;
    end
  end

  // outputs
  always_comb begin
    in_ready  = (state_q == IDLE) && !clear;
    busy      = (state_q != IDLE);
    acc_out   = acc_q;
    out_valid = out_valid_q;
    ovf       = ovf_q;
    uf        = uf_q;
  end
endmodule
